// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Definitions shared by the vending controller blocks:
//   - vend_state_t : coin/credit FSM states (IDLE, CREDIT, CHANGE)
//   - COIN_*       : coin codes presented by the slot front end
//   - DEF_*        : default credit ceiling and coin values, in 25-cent units
//   - coin_is_valid: true for the three one-hot coin codes
// ---------------------------------------------------------------------------
package vend_pkg;

   // IDLE holds no credit, CREDIT holds some, CHANGE waits for the dispenser
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_CHANGE = 2'd2
   } vend_state_t;

   localparam logic [2:0] COIN_NONE = 3'b000;
   localparam logic [2:0] COIN_25   = 3'b001;
   localparam logic [2:0] COIN_50   = 3'b010;
   localparam logic [2:0] COIN_100  = 3'b100;

   localparam int DEF_MAX_UNITS = 8;
   localparam int DEF_VAL_C0    = 1;
   localparam int DEF_VAL_C1    = 2;
   localparam int DEF_VAL_C2    = 4;

   // Only the three one-hot codes are real coins; anything else is refused
   function automatic logic coin_is_valid(input logic [2:0] code);
      return (code == COIN_25) || (code == COIN_50) || (code == COIN_100);
   endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// ---------------------------------------------------------------------------
// coin_edge_detect
// Turns the coin-present level from the slot into a single-cycle insertion
// event. Holding got_coin high for any number of cycles yields one event.
//
// Build option: define COIN_SYNC_EN to pass got_coin and coin through a
// two-flop synchroniser before edge detection (mechanical slot or
// asynchronous front end). Without it the inputs are taken as synchronous
// to clk.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   got_coin  in   coin-present level
//   coin      in   coin code, valid while got_coin is high
//   coin_evt  out  one-cycle pulse on each rising edge of got_coin
//   coin_code out  coin code aligned with coin_evt
// ---------------------------------------------------------------------------
module coin_edge_detect
   import vend_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       got_coin,
   input  logic [2:0] coin,
   output logic       coin_evt,
   output logic [2:0] coin_code
);

   logic       got_level;
   logic [2:0] code_level;
   logic       got_prev;

`ifdef COIN_SYNC_EN
   logic       got_meta;
   logic       got_sync;
   logic [2:0] coin_meta;
   logic [2:0] coin_sync;

   // Two-stage synchroniser; the code travels alongside the level so both
   // arrive at the edge detector in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         got_meta  <= 1'b0;
         got_sync  <= 1'b0;
         coin_meta <= COIN_NONE;
         coin_sync <= COIN_NONE;
      end else begin
         got_meta  <= got_coin;
         got_sync  <= got_meta;
         coin_meta <= coin;
         coin_sync <= coin_meta;
      end
   end

   assign got_level  = got_sync;
   assign code_level = coin_sync;
`else
   assign got_level  = got_coin;
   assign code_level = coin;
`endif

   // History flop clears to 0, so a level already high when reset is
   // released is seen as a fresh insertion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         got_prev <= 1'b0;
      end else begin
         got_prev <= got_level;
      end
   end

   assign coin_evt  = got_level & ~got_prev;
   assign coin_code = code_level;

endmodule

// File: rtl/coin_credit_fsm.sv
// ---------------------------------------------------------------------------
// coin_credit_fsm
// Coin-credit accumulator for the vending controller. Adds coin values to a
// bounded credit register, refuses invalid or overflowing coins, deducts the
// product price on a vend request and hands back change or a full refund
// through a valid/ack handshake.
//
// Build option: COIN_SYNC_EN (see coin_edge_detect) adds a two-flop
// synchroniser on got_coin/coin, giving 3-cycle instead of 1-cycle coin
// latency. vend_req, cancel and change_ack are never synchronised.
//
// Parameters:
//   MAX_UNITS    credit ceiling in 25-cent units
//   VAL_C0/1/2   units credited for coin codes 001 / 010 / 100
//   CW           credit width, derived from MAX_UNITS
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   got_coin,coin coin-present level and coin code from the slot
//   price_units   price of the selected product
//   vend_req      single-cycle buy request
//   cancel        single-cycle refund request
//   change_ack    dispenser has taken change_units
//   credit        current credit (registered)
//   coin_accept   one-cycle pulse: coin added to credit
//   coin_reject   one-cycle pulse: coin refused
//   vend_ok       one-cycle pulse: price deducted
//   vend_fail     one-cycle pulse: insufficient credit or zero price
//   change_valid  change/refund pending, held until acked
//   change_units  amount to return, stable while change_valid
// ---------------------------------------------------------------------------
module coin_credit_fsm
   import vend_pkg::*;
#(
   parameter int  MAX_UNITS = DEF_MAX_UNITS,
   parameter int  VAL_C0    = DEF_VAL_C0,
   parameter int  VAL_C1    = DEF_VAL_C1,
   parameter int  VAL_C2    = DEF_VAL_C2,
   localparam int CW        = $clog2(MAX_UNITS + 1)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          got_coin,
   input  logic [2:0]    coin,
   input  logic [CW-1:0] price_units,
   input  logic          vend_req,
   input  logic          cancel,
   input  logic          change_ack,
   output logic [CW-1:0] credit,
   output logic          coin_accept,
   output logic          coin_reject,
   output logic          vend_ok,
   output logic          vend_fail,
   output logic          change_valid,
   output logic [CW-1:0] change_units
);

   localparam logic [CW:0] MAX_WIDE = (CW + 1)'(MAX_UNITS);

   vend_state_t   state;
   vend_state_t   state_nxt;
   logic [CW-1:0] credit_nxt;
   logic [CW-1:0] change_nxt;
   logic          accept_nxt;
   logic          reject_nxt;
   logic          ok_nxt;
   logic          fail_nxt;

   logic          coin_evt;
   logic [2:0]    coin_code;
   logic          coin_seen;
   logic [CW:0]   coin_val;
   logic [CW:0]   credit_sum;
   logic          price_ok;
   logic [CW-1:0] remainder;

   coin_edge_detect u_edge (
      .clk       (clk),
      .rst_n     (rst_n),
      .got_coin  (got_coin),
      .coin      (coin),
      .coin_evt  (coin_evt),
      .coin_code (coin_code)
   );

   // Map the captured code onto its value. Code 000 on an edge is not a
   // coin at all and produces no pulse, so it is filtered out here too.
   always_comb begin
      coin_val = '0;
      case (coin_code)
         COIN_25:  coin_val = (CW + 1)'(VAL_C0);
         COIN_50:  coin_val = (CW + 1)'(VAL_C1);
         COIN_100: coin_val = (CW + 1)'(VAL_C2);
         default:  coin_val = '0;
      endcase
   end

   assign coin_seen  = coin_evt && (coin_code != COIN_NONE);
   // One extra bit so an overflowing coin is detected rather than wrapping
   assign credit_sum = {1'b0, credit} + coin_val;
   assign price_ok   = (price_units != '0) && (credit >= price_units);
   assign remainder  = credit - price_units;

   // Next-state and next-output decode. Within a cycle cancel outranks
   // vend_req, which outranks a coin edge; a coin edge that loses is
   // refused so the customer always sees exactly one coin pulse. A cancel
   // with no credit is a no-op and does not block a vend or a coin.
   always_comb begin
      state_nxt  = state;
      credit_nxt = credit;
      change_nxt = change_units;
      accept_nxt = 1'b0;
      reject_nxt = 1'b0;
      ok_nxt     = 1'b0;
      fail_nxt   = 1'b0;

      case (state)
         ST_IDLE, ST_CREDIT: begin
            if (cancel && (state == ST_CREDIT)) begin
               change_nxt = credit;
               credit_nxt = '0;
               state_nxt  = ST_CHANGE;
               reject_nxt = coin_seen;
            end else if (vend_req) begin
               reject_nxt = coin_seen;
               if (price_ok) begin
                  ok_nxt     = 1'b1;
                  change_nxt = remainder;
                  credit_nxt = '0;
                  state_nxt  = (remainder != '0) ? ST_CHANGE : ST_IDLE;
               end else begin
                  fail_nxt = 1'b1;
               end
            end else if (coin_seen) begin
               if (coin_is_valid(coin_code) && (credit_sum <= MAX_WIDE)) begin
                  accept_nxt = 1'b1;
                  credit_nxt = credit_sum[CW-1:0];
                  state_nxt  = ST_CREDIT;
               end else begin
                  reject_nxt = 1'b1;
               end
            end
         end

         ST_CHANGE: begin
            // Credit is held at zero while change is pending, so coins
            // and purchases are refused until the dispenser acknowledges
            reject_nxt = coin_seen;
            fail_nxt   = vend_req;
            if (change_ack) begin
               change_nxt = '0;
               state_nxt  = ST_IDLE;
            end
         end

         default: begin
            state_nxt  = ST_IDLE;
            credit_nxt = '0;
            change_nxt = '0;
         end
      endcase
   end

   // State and all outputs are registered; change_valid follows the
   // registered state so it is glitch-free toward the dispenser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         credit       <= '0;
         change_units <= '0;
         coin_accept  <= 1'b0;
         coin_reject  <= 1'b0;
         vend_ok      <= 1'b0;
         vend_fail    <= 1'b0;
         change_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         credit       <= credit_nxt;
         change_units <= change_nxt;
         coin_accept  <= accept_nxt;
         coin_reject  <= reject_nxt;
         vend_ok      <= ok_nxt;
         vend_fail    <= fail_nxt;
         change_valid <= (state_nxt == ST_CHANGE);
      end
   end

endmodule

// File: tb/tb_coin_credit_fsm.sv
// ---------------------------------------------------------------------------
// tb_coin_credit_fsm
// Self-checking bench for coin_credit_fsm. A behavioural model tracks
// credit, pending change and the expected pulses from the customer-level
// rules and is compared with the DUT every cycle; directed sequences add
// hand-computed checks. Build with or without COIN_SYNC_EN to match the RTL.
// ---------------------------------------------------------------------------
module tb_coin_credit_fsm;

   localparam int CW = 4;

`ifdef COIN_SYNC_EN
   localparam int LAT = 3;
   localparam int TAP = 2;
`else
   localparam int LAT = 1;
   localparam int TAP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          got_coin = 1'b0;
   logic [2:0]    coin = 3'b000;
   logic [CW-1:0] price_units = '0;
   logic          vend_req = 1'b0;
   logic          cancel = 1'b0;
   logic          change_ack = 1'b0;
   logic [CW-1:0] credit;
   logic          coin_accept;
   logic          coin_reject;
   logic          vend_ok;
   logic          vend_fail;
   logic          change_valid;
   logic [CW-1:0] change_units;

   int total = 0;
   int bad = 0;
   int acc_cnt = 0;
   int rej_cnt = 0;

   coin_credit_fsm dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .got_coin     (got_coin),
      .coin         (coin),
      .price_units  (price_units),
      .vend_req     (vend_req),
      .cancel       (cancel),
      .change_ack   (change_ack),
      .credit       (credit),
      .coin_accept  (coin_accept),
      .coin_reject  (coin_reject),
      .vend_ok      (vend_ok),
      .vend_fail    (vend_fail),
      .change_valid (change_valid),
      .change_units (change_units)
   );

   always #5 clk = ~clk;

   function automatic void check_output(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endfunction

   // Behavioural model: credit in units, a pending-change flag and amount
   int         m_credit;
   int         m_units;
   bit         m_chg;
   bit         e_acc, e_rej, e_ok, e_fail;
   bit         gh [4];
   logic [2:0] chh [4];
   bit         m_evt;
   logic [2:0] m_code;
   int         m_val;
   bit         m_nz;

   always @(posedge clk) begin
      e_acc = 0; e_rej = 0; e_ok = 0; e_fail = 0;
      if (!rst_n) begin
         m_credit = 0; m_units = 0; m_chg = 0;
         for (int i = 0; i < 4; i++) begin
            gh[i] = 0;
            chh[i] = 3'b000;
         end
      end else begin
         for (int i = 3; i > 0; i--) begin
            gh[i] = gh[i-1];
            chh[i] = chh[i-1];
         end
         gh[0] = got_coin;
         chh[0] = coin;
         m_evt  = gh[TAP] && !gh[TAP+1];
         m_code = chh[TAP];
         m_val  = (m_code == 3'b001) ? 1 : (m_code == 3'b010) ? 2 : (m_code == 3'b100) ? 4 : 0;
         m_nz   = m_evt && (m_code != 3'b000);
         if (m_chg) begin
            e_rej  = m_nz;
            e_fail = vend_req;
            if (change_ack) begin
               m_chg = 0;
               m_units = 0;
            end
         end else if (cancel && m_credit > 0) begin
            m_units = m_credit;
            m_credit = 0;
            m_chg = 1;
            e_rej = m_nz;
         end else if (vend_req) begin
            e_rej = m_nz;
            if (price_units != 0 && m_credit >= int'(price_units)) begin
               e_ok = 1;
               m_units = m_credit - int'(price_units);
               m_credit = 0;
               m_chg = (m_units != 0);
            end else begin
               e_fail = 1;
            end
         end else if (m_nz) begin
            if (m_val != 0 && m_credit + m_val <= 8) begin
               e_acc = 1;
               m_credit = m_credit + m_val;
            end else begin
               e_rej = 1;
            end
         end
      end
      #1;
      check_output("model_credit", int'(credit), m_credit);
      check_output("model_change_units", int'(change_units), m_units);
      check_output("model_change_valid", int'(change_valid), int'(m_chg));
      check_output("model_coin_accept", int'(coin_accept), int'(e_acc));
      check_output("model_coin_reject", int'(coin_reject), int'(e_rej));
      check_output("model_vend_ok", int'(vend_ok), int'(e_ok));
      check_output("model_vend_fail", int'(vend_fail), int'(e_fail));
      if (coin_accept) acc_cnt++;
      if (coin_reject) rej_cnt++;
   end

   task automatic insert_coin(input logic [2:0] code);
      @(negedge clk);
      coin = code;
      got_coin = 1'b1;
      repeat (5) @(negedge clk);
      got_coin = 1'b0;
      coin = 3'b000;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_vend(input int price);
      @(negedge clk);
      price_units = CW'(price);
      vend_req = 1'b1;
      @(negedge clk);
      vend_req = 1'b0;
   endtask

   task automatic pulse_cancel();
      @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      change_ack = 1'b1;
      @(negedge clk);
      change_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      $display("[TB] coin latency under test: %0d", LAT);
      repeat (3) @(negedge clk);
      check_output("reset_credit", int'(credit), 0);
      check_output("reset_change_valid", int'(change_valid), 0);
      check_output("reset_pulses", int'({coin_accept, coin_reject, vend_ok, vend_fail}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // cancel with no credit does nothing
      pulse_cancel();
      check_output("idle_cancel_valid", int'(change_valid), 0);

      // first coin, measuring latency from the raw rise
      coin = 3'b001;
      got_coin = 1'b1;
      n = 0;
      while (credit == 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_output("coin_latency", n, LAT);
      repeat (5 - n) @(negedge clk);
      got_coin = 1'b0;
      coin = 3'b000;
      repeat (4) @(negedge clk);
      check_output("credit_after_25", int'(credit), 1);
      insert_coin(3'b010);
      check_output("credit_after_50", int'(credit), 3);
      insert_coin(3'b100);
      check_output("credit_after_100", int'(credit), 7);
      check_output("accept_count", acc_cnt, 3);
      check_output("reject_count_clean", rej_cnt, 0);

      // overflow, exact fill, invalid code
      insert_coin(3'b010);
      check_output("overflow_credit", int'(credit), 7);
      check_output("overflow_reject_count", rej_cnt, 1);
      insert_coin(3'b001);
      check_output("fill_to_max", int'(credit), 8);
      insert_coin(3'b011);
      check_output("invalid_code_reject_count", rej_cnt, 2);
      check_output("invalid_code_credit", int'(credit), 8);

      // refund everything, then rebuild 7
      pulse_cancel();
      check_output("refund_8_units", int'(change_units), 8);
      pulse_ack();
      insert_coin(3'b001);
      insert_coin(3'b010);
      insert_coin(3'b100);
      check_output("rebuilt_credit", int'(credit), 7);

      // vend with change
      pulse_vend(5);
      check_output("vend_ok_pulse", int'(vend_ok), 1);
      check_output("vend_credit_cleared", int'(credit), 0);
      check_output("vend_change_valid", int'(change_valid), 1);
      check_output("vend_change_units", int'(change_units), 2);
      insert_coin(3'b001);
      check_output("coin_in_change_reject_count", rej_cnt, 3);
      check_output("change_units_stable", int'(change_units), 2);
      pulse_vend(1);
      check_output("vend_in_change_fail", int'(vend_fail), 1);
      pulse_ack();
      check_output("ack_valid_low", int'(change_valid), 0);
      check_output("ack_units_cleared", int'(change_units), 0);

      // insufficient credit and zero price
      insert_coin(3'b001);
      insert_coin(3'b010);
      pulse_vend(4);
      check_output("vend_short_fail", int'(vend_fail), 1);
      check_output("vend_short_credit", int'(credit), 3);
      pulse_vend(0);
      check_output("vend_zero_price_fail", int'(vend_fail), 1);
      check_output("vend_zero_price_credit", int'(credit), 3);

      // exact-price vend leaves no change pending
      pulse_vend(3);
      check_output("exact_vend_no_change", int'(change_valid), 0);

      // cancel and coin edge in the same cycle
      insert_coin(3'b100);
      check_output("credit_4", int'(credit), 4);
      @(negedge clk);
      coin = 3'b001;
      got_coin = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check_output("cancel_coin_refund", int'(change_units), 4);
      check_output("cancel_coin_reject", int'(coin_reject), 1);
      check_output("cancel_coin_credit", int'(credit), 0);
      repeat (3) @(negedge clk);
      got_coin = 1'b0;
      coin = 3'b000;
      repeat (4) @(negedge clk);
      pulse_ack();

      // asynchronous reset mid-cycle with credit held
      insert_coin(3'b100);
      check_output("credit_before_reset", int'(credit), 4);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_reset_credit", int'(credit), 0);
      check_output("async_reset_outputs",
                   int'({coin_accept, coin_reject, vend_ok, vend_fail, change_valid}), 0);
      check_output("async_reset_change_units", int'(change_units), 0);

      // a coin held through reset release counts as one insertion
      @(negedge clk);
      coin = 3'b001;
      got_coin = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT) @(negedge clk);
      check_output("coin_through_reset", int'(credit), 1);
      got_coin = 1'b0;
      coin = 3'b000;
      repeat (4) @(negedge clk);

      // ack without pending change is ignored
      pulse_ack();
      check_output("stray_ack_credit", int'(credit), 1);
      check_output("stray_ack_valid", int'(change_valid), 0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
